// File: rtl/alu_dec_unit.sv
// RV32I ALU operation decoder plus single-cycle ALU; the result is also
// offered registered on Out_q with one clock of latency.
module alu_dec_unit #(
  parameter int XLEN = 32
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct,
  input  logic            add_rshift_type,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [3:0]      ALUop,
  output logic [XLEN-1:0] Out,
  output logic [XLEN-1:0] Out_q
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLT    = 4'd5,
    OP_SLTU   = 4'd6,
    OP_SLL    = 4'd7,
    OP_SRA    = 4'd8,
    OP_SRL    = 4'd9,
    OP_COPY_B = 4'd10,
    OP_XXX    = 4'd15
  } aluop_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  aluop_e                 w_op;
  aluop_e                 w_arith_op;
  logic                   w_is_imm;
  logic [SHW-1:0]         w_shamt;
  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic [XLEN-1:0]        w_out;
  logic [XLEN-1:0]        r_out_q;

  // Register-register and register-immediate share one funct decode; the
  // immediate form has no SUB, and inst[30] there is part of the immediate.
  always_comb begin
    w_arith_op = OP_XXX;
    case (funct)
      3'b000:  w_arith_op = (add_rshift_type && !w_is_imm) ? OP_SUB : OP_ADD;
      3'b001:  w_arith_op = OP_SLL;
      3'b010:  w_arith_op = OP_SLT;
      3'b011:  w_arith_op = OP_SLTU;
      3'b100:  w_arith_op = OP_XOR;
      3'b101:  w_arith_op = add_rshift_type ? OP_SRA : OP_SRL;
      3'b110:  w_arith_op = OP_OR;
      default: w_arith_op = OP_AND;
    endcase
  end

  assign w_is_imm = (opcode == OPC_OP_IMM);

  always_comb begin
    w_op = OP_XXX;
    case (opcode)
      OPC_OP, OPC_OP_IMM:                   w_op = w_arith_op;
      OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_AUIPC:         w_op = OP_ADD;
      OPC_LUI:                              w_op = OP_COPY_B;
      default:                              w_op = OP_XXX;
    endcase
  end

  assign ALUop   = w_op;
  assign w_shamt = B[SHW-1:0];
  assign w_a_s   = A;
  assign w_b_s   = B;

  always_comb begin
    w_out = '0;
    case (w_op)
      OP_ADD:    w_out = A + B;
      OP_SUB:    w_out = A - B;
      OP_AND:    w_out = A & B;
      OP_OR:     w_out = A | B;
      OP_XOR:    w_out = A ^ B;
      OP_SLT:    w_out = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
      OP_SLTU:   w_out = {{(XLEN-1){1'b0}}, (A < B)};
      OP_SLL:    w_out = A << w_shamt;
      OP_SRA:    w_out = w_a_s >>> w_shamt;
      OP_SRL:    w_out = A >> w_shamt;
      OP_COPY_B: w_out = B;
      default:   w_out = '0;
    endcase
  end

  assign Out = w_out;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_out_q <= '0;
    else          r_out_q <= w_out;
  end

  assign Out_q = r_out_q;

endmodule

// File: tb/tb_alu_dec_unit.sv
// Randomized bench for alu_dec_unit: a table-driven behavioural model predicts
// ALUop/Out every cycle and a one-deep expectation tracks Out_q.
module tb_alu_dec_unit;

  logic        Clock;
  logic        Reset_n;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic [31:0] Out_q;

  int n_cmp = 0;
  int n_err = 0;
  logic        cmp_en = 1'b0;
  logic [31:0] exp_q  = 32'h0;

  alu_dec_unit #(.XLEN(32)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .opcode(opcode), .funct(funct),
    .add_rshift_type(add_rshift_type), .A(A), .B(B),
    .ALUop(ALUop), .Out(Out), .Out_q(Out_q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Operation chosen by funct for the arithmetic opcodes; entries 0 and 5
  // are replaced when inst[30] selects the alternate form.
  function automatic logic [3:0] m_op(input logic [6:0] opc, input logic [2:0] f,
                                      input logic t);
    logic [3:0] tab [8];
    tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd9, 4'd3, 4'd2};
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      if (f == 3'd5 && t) return 4'd8;
      if (f == 3'd0 && t && opc == 7'b0110011) return 4'd1;
      return tab[f];
    end
    if (opc inside {7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                    7'b1100111, 7'b0010111}) return 4'd0;
    if (opc == 7'b0110111) return 4'd10;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_res(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh  = int'(b % 32);
    ext = {{32{a[31]}}, a};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return 32'(ext >> sh);
      4'd9:  return a >> sh;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_out_now();
    return m_res(m_op(opcode, funct, add_rshift_type), A, B);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t op=%b f=%0d ty=%0b A=%08h B=%08h)",
               name, act, exp, $time, opcode, funct, add_rshift_type, A, B);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f, input logic t,
                       input logic [31:0] a, input logic [31:0] b);
    opcode = op; funct = f; add_rshift_type = t; A = a; B = b;
  endtask

  task automatic step_drive(input logic [6:0] op, input logic [2:0] f, input logic t,
                            input logic [31:0] a, input logic [31:0] b);
    @(posedge Clock);
    #2;
    drive(op, f, t, a, b);
    #1;
  endtask

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) exp_q <= 32'h0;
    else          exp_q <= m_out_now();
  end

  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("cyc_aluop", {28'h0, ALUop}, {28'h0, m_op(opcode, funct, add_rshift_type)});
      chk("cyc_out", Out, m_out_now());
      chk("cyc_out_q", Out_q, exp_q);
    end
  end

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  initial begin
    logic [6:0] opc_list [10];
    opc_list = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111, 7'b0110011};
    Reset_n = 1'b0;
    drive(R, 3'd0, 1'b0, 32'h0, 32'h0);
    #3;
    chk("reset_out_q", Out_q, 32'h0);
    @(posedge Clock);
    #1;
    chk("reset_hold_out_q", Out_q, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    cmp_en  = 1'b1;

    step_drive(I, 3'd0, 1'b1, 32'h7FFF_FFFF, 32'h1);
    chk("itype_add_op", {28'h0, ALUop}, 32'd0);
    chk("itype_add_wrap", Out, 32'h8000_0000);
    step_drive(R, 3'd5, 1'b1, 32'h8000_0000, 32'hFFFF_FFE4);
    chk("sra", Out, 32'hF800_0000);
    step_drive(R, 3'd5, 1'b0, 32'h8000_0000, 32'hFFFF_FFE4);
    chk("srl", Out, 32'h0800_0000);
    step_drive(R, 3'd1, 1'b0, 32'h8000_0000, 32'hFFFF_FFE4);
    chk("sll", Out, 32'h0000_0000);
    step_drive(R, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h1);
    chk("slt", Out, 32'd1);
    step_drive(R, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'h1);
    chk("sltu", Out, 32'd0);
    step_drive(7'b0110111, 3'd3, 1'b1, 32'hDEAD_BEEF, 32'h1234_5000);
    chk("lui_op", {28'h0, ALUop}, 32'd10);
    chk("lui_out", Out, 32'h1234_5000);
    step_drive(7'b1111111, 3'd0, 1'b0, 32'h5, 32'h7);
    chk("bad_opc_op", {28'h0, ALUop}, 32'd15);
    chk("bad_opc_out", Out, 32'h0);
    step_drive(7'b1100011, 3'd5, 1'b1, 32'h100, 32'hFFFF_FFFC);
    chk("branch_add", Out, 32'h0000_00FC);

    step_drive(R, 3'd0, 1'b1, 32'h5, 32'h7);
    chk("rtype_sub_op", {28'h0, ALUop}, 32'd1);
    chk("rtype_sub", Out, 32'hFFFF_FFFE);
    @(posedge Clock);
    #1;
    chk("sub_out_q", Out_q, 32'hFFFF_FFFE);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_out_q", Out_q, 32'h0);
    chk("async_rst_out", Out, 32'hFFFF_FFFE);
    @(negedge Clock);
    #1;
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    chk("post_rst_load", Out_q, 32'hFFFF_FFFE);

    for (int i = 0; i < 3000; i++) begin
      @(posedge Clock);
      #2;
      if ($urandom_range(0, 9) == 0) opcode = 7'($urandom);
      else opcode = opc_list[$urandom_range(0, 9)];
      funct = 3'($urandom);
      add_rshift_type = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       A = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        1:       A = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: A = $urandom;
      endcase
      B = ($urandom_range(0, 3) == 0) ? A : $urandom;
      if ($urandom_range(0, 49) == 0) begin
        #1;
        Reset_n = 1'b0;
        #1;
        chk("rand_async_rst", Out_q, 32'h0);
        #2;
        Reset_n = 1'b1;
      end
    end

    @(posedge Clock);
    #2;
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_dec_unit.md
ALU_DEC_UNIT -- requirements
Module: alu_dec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is required to be supported.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: Clock (rising-edge) and Reset_n (asynchronous, active-low).
REQ-003 Clock  input  1  system clock; only Out_q is sequential.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 opcode  input  7  RV32I instruction opcode field, inst[6:0].
REQ-006 funct  input  3  funct3 field, inst[14:12].
REQ-007 add_rshift_type  input  1  inst[30]; selects SUB vs ADD and SRA vs SRL.
REQ-008 A  input  32  first operand.
REQ-009 B  input  32  second operand, either register or immediate.
REQ-010 ALUop  output  4  decoded operation, combinational.
REQ-011 Out  output  32  combinational ALU result.
REQ-012 Out_q  output  32  Out registered on Clock.

Function
REQ-013 ALUop encoding SHALL be: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRA=8, SRL=9, COPY_B=10, XXX=15.
REQ-014 R-type (opcode 0110011) funct to ALUop SHALL be:
- 000 -> SUB if add_rshift_type=1, else ADD.
- 001 -> SLL; 010 -> SLT; 011 -> SLTU; 100 -> XOR.
- 101 -> SRA if add_rshift_type=1, else SRL.
- 110 -> OR; 111 -> AND.
REQ-015 I-type arithmetic (opcode 0010011) SHALL decode as R-type, except funct 000 is always ADD and add_rshift_type is ignored.
REQ-016 The following opcodes SHALL decode to ADD, independent of funct and add_rshift_type: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111.
REQ-017 LUI (0110111) SHALL decode to COPY_B.
REQ-018 Any other opcode SHALL decode to XXX.
REQ-019 ALU operations SHALL be:
- ADD/SUB: A+B / A-B, modulo 2^32, no carry or overflow output.
- AND/OR/XOR: bitwise.
- SLT: 32'd1 if signed(A) < signed(B), else 0.
- SLTU: 32'd1 if unsigned(A) < unsigned(B), else 0.
REQ-020 Shifts SHALL use B[4:0] as shift amount and ignore B[31:5]:
- SLL: A shifted left, zero-filled.
- SRL: logical right shift, zero-filled.
- SRA: arithmetic right shift, sign-filled from A[31].
REQ-021 COPY_B SHALL output B; XXX, and any undefined ALUop value, SHALL output 32'h0.
REQ-022 ALUop and Out SHALL be purely combinational, zero-cycle latency, settled within 1 ns of any input change in simulation.
REQ-023 Out_q SHALL capture Out on every rising Clock edge while Reset_n=1, giving one-cycle latency; there is no enable.

Reset
REQ-024 Reset_n=0 SHALL immediately force Out_q to 32'h0, independent of Clock.
REQ-025 Reset SHALL NOT affect ALUop or Out, which remain combinational functions of the inputs.
REQ-026 After Reset_n rises, the first rising Clock edge SHALL load the current Out into Out_q.

Verification
REQ-027 R-type funct 000, type=1, A=0x00000005, B=0x00000007 -> ALUop=1, Out=0xFFFFFFFE; Out_q=0xFFFFFFFE one edge later.
REQ-028 I-type funct 000, type=1, A=0x7FFFFFFF, B=0x00000001 -> ALUop=0, Out=0x80000000 (wraps, type ignored).
REQ-029 Shifts, A=0x80000000, B=0xFFFFFFE4 (shamt=4):
- R funct 101, type=1 -> Out=0xF8000000.
- R funct 101, type=0 -> Out=0x08000000.
- R funct 001 -> Out=0x00000000.
REQ-030 Compares, A=0xFFFFFFFF, B=0x00000001:
- funct 010 -> Out=1.
- funct 011 -> Out=0.
REQ-031 Fixed-op opcodes:
- LUI, B=0x12345000 -> ALUop=10, Out=0x12345000.
- opcode 1111111 -> ALUop=15, Out=0.
- BRANCH, A=0x100, B=0xFFFFFFFC -> Out=0x000000FC.
REQ-032 With Out_q=0xFFFFFFFE, drive Reset_n low between Clock edges -> Out_q=0 immediately; Out unchanged.
